// File: rtl/mul_feed.sv
// mul_feed: operand sequencer for the chunked multiply/accumulate path.
// Operand loading: two NUM_BITS operands are captured as CHUNKS chunks of
// REGISTER_SIZE bits each, least-significant chunk first.
// Streaming: every (a[col], b[row]) pair is then replayed row by row.
// Each row is tagged with its row index as start_padding, so the partial-product
// store can shift that row into place.
// The stream is throttled by ready_in.
module mul_feed #(
    parameter  int REGISTER_SIZE = 32,
    parameter  int NUM_BITS      = 2048,
    localparam int CHUNKS        = NUM_BITS / REGISTER_SIZE,
    localparam int CW            = $clog2(CHUNKS) + 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] a_in,
    input  logic [REGISTER_SIZE-1:0] b_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [REGISTER_SIZE-1:0] a_chunk_out,
    output logic [REGISTER_SIZE-1:0] b_chunk_out,
    output logic [CW-1:0]            start_padding_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     last_out,
    output logic                     done_out
);

    localparam int            IW   = $clog2(CHUNKS);
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

    state_t                   state, state_nx;
    logic [CW-1:0]            load_cnt, load_cnt_nx;
    logic [CW-1:0]            row, row_nx;
    logic [CW-1:0]            col, col_nx;
    logic [REGISTER_SIZE-1:0] a_mem [CHUNKS];
    logic [REGISTER_SIZE-1:0] b_mem [CHUNKS];

    // Operand storage: written only while loading.
    // It is deliberately left out of reset, because its contents are
    // meaningless until a full load has completed.
    always_ff @(posedge clk_in) begin
        if (state == LOAD && valid_in) begin
            a_mem[load_cnt[IW-1:0]] <= a_in;
            b_mem[load_cnt[IW-1:0]] <= b_in;
        end
    end

    // State and counter registers.
    // Reset returns to an idle LOAD, so any stream in flight is abandoned.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= LOAD;
            load_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            state    <= state_nx;
            load_cnt <= load_cnt_nx;
            row      <= row_nx;
            col      <= col_nx;
        end
    end

    // Next-state logic.
    // In LOAD, the counter advances on each accepted beat.
    // In STREAM, col advances on each transfer and wraps into row.
    always_comb begin
        state_nx    = state;
        load_cnt_nx = load_cnt;
        row_nx      = row;
        col_nx      = col;
        case (state)
            LOAD: begin
                if (valid_in) begin
                    if (load_cnt == LAST) begin
                        load_cnt_nx = '0;
                        row_nx      = '0;
                        col_nx      = '0;
                        state_nx    = STREAM;
                    end else begin
                        load_cnt_nx = load_cnt + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (ready_in) begin
                    if (col == LAST && row == LAST) begin
                        state_nx = DONE;
                    end else if (col == LAST) begin
                        col_nx = '0;
                        row_nx = row + 1'b1;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
            DONE:    state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Outputs are decoded from registered state only; there is no path from ready_in.
    // Data outputs are gated by STREAM, so an asynchronous reset forces them
    // to zero at once.
    always_comb begin
        ready_out         = (state == LOAD);
        valid_out         = (state == STREAM);
        done_out          = (state == DONE);
        a_chunk_out       = '0;
        b_chunk_out       = '0;
        start_padding_out = '0;
        last_out          = 1'b0;
        if (state == STREAM) begin
            a_chunk_out       = a_mem[col[IW-1:0]];
            b_chunk_out       = b_mem[row[IW-1:0]];
            start_padding_out = row;
            last_out          = (col == LAST);
        end
    end

endmodule

// File: tb/tb_mul_feed.sv
// Bench for mul_feed.
// It drives a small instance (CHUNKS=4) through directed and randomized scenarios.
// It also drives a default-size instance (CHUNKS=64) through one full random pair.
// Expected beats come from the plain rule: beat k = (A[k%C], B[k/C], k/C, k%C==C-1).
module tb_mul_feed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // small instance, CHUNKS=4
    logic [31:0] a = '0, b = '0;
    logic        vin = 1'b0, rin = 1'b0;
    logic        rdy, vout, last, done;
    logic [31:0] achunk, bchunk;
    logic [2:0]  pad;

    // default instance, CHUNKS=64
    logic [31:0] ba = '0, bb = '0;
    logic        bvin = 1'b0, brin = 1'b0;
    logic        brdy, bvout, blast, bdone;
    logic [31:0] bachunk, bbchunk;
    logic [6:0]  bpad;

    int checks = 0;
    int passed = 0;

    logic [31:0] cur_a [4];
    logic [31:0] cur_b [4];
    int          gaps  [4];
    logic [31:0] big_a [64];
    logic [31:0] big_b [64];

    always #5 clk = ~clk;

    mul_feed #(.REGISTER_SIZE(32), .NUM_BITS(128)) dut (
        .clk_in(clk), .rst_in(rst_n), .a_in(a), .b_in(b), .valid_in(vin),
        .ready_out(rdy), .a_chunk_out(achunk), .b_chunk_out(bchunk),
        .start_padding_out(pad), .valid_out(vout), .ready_in(rin),
        .last_out(last), .done_out(done)
    );

    mul_feed dut_big (
        .clk_in(clk), .rst_in(rst_n), .a_in(ba), .b_in(bb), .valid_in(bvin),
        .ready_out(brdy), .a_chunk_out(bachunk), .b_chunk_out(bbchunk),
        .start_padding_out(bpad), .valid_out(bvout), .ready_in(brin),
        .last_out(blast), .done_out(bdone)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Load cur_a/cur_b with gaps[i] idle cycles ahead of chunk i.
    // The task returns at the negedge where the stream should already be valid.
    task automatic load();
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                chk("ld_ready_gap", rdy, 1'b1);
                vin = 1'b0;
                a   = $urandom;
                b   = $urandom;
            end
            @(negedge clk);
            chk("ld_ready", rdy, 1'b1);
            chk("ld_valid", vout, 1'b0);
            vin = 1'b1;
            a   = cur_a[i];
            b   = cur_b[i];
        end
        @(negedge clk);
        vin = 1'b0;
        chk("ld_ready_fall", rdy, 1'b0);
        chk("ld_valid_rise", vout, 1'b1);
    endtask

    // Stream nbeats beats, with random backpressure if bp is set.
    // If junk is set, garbage input beats are offered throughout the stream.
    task automatic stream(input int nbeats, input bit bp, input bit junk);
        int k   = 0;
        int cyc = 0;
        while (k < nbeats && cyc < 400) begin
            chk("s_valid", vout, 1'b1);
            chk("s_ready", rdy, 1'b0);
            chk("s_a", achunk, cur_a[k % 4]);
            chk("s_b", bchunk, cur_b[k / 4]);
            chk("s_pad", pad, k / 4);
            chk("s_last", last, (k % 4) == 3);
            chk("s_done", done, 1'b0);
            rin = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                vin = 1'b1;
                a   = 32'hDEAD;
                b   = 32'hDEAD;
            end
            if (rin) k++;
            cyc++;
            @(negedge clk);
        end
        chk("s_beat_count", k, nbeats);
        rin = 1'b0;
        vin = 1'b0;
    endtask

    task automatic finish_pulse();
        chk("done_pulse", done, 1'b1);
        chk("done_valid", vout, 1'b0);
        chk("done_ready", rdy, 1'b0);
        @(negedge clk);
        chk("done_clear", done, 1'b0);
        chk("reload_ready", rdy, 1'b1);
    endtask

    initial begin
        int k, lasts, dones, maxpad;

        // Reset state, checked while the reset is still asserted.
        #3;
        chk("rst_ready", rdy, 1'b1);
        chk("rst_valid", vout, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_pad", pad, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_ready", rdy, 1'b1);

        // Basic stream: back-to-back load, ready_in always high.
        cur_a = '{32'd1, 32'd2, 32'd3, 32'd4};
        cur_b = '{32'd10, 32'd20, 32'd30, 32'd40};
        gaps  = '{0, 0, 0, 0};
        load();
        stream(16, 1'b0, 1'b0);
        finish_pulse();

        // Backpressure with random ready_in.
        load();
        stream(16, 1'b1, 1'b0);
        finish_pulse();

        // Load gaps (valid pattern 1,0,0,1,1,0,1) and junk input during the stream.
        cur_a = '{$urandom, $urandom, $urandom, $urandom};
        cur_b = '{$urandom, $urandom, $urandom, $urandom};
        gaps  = '{0, 2, 0, 1};
        load();
        stream(16, 1'b1, 1'b1);
        finish_pulse();

        // The next load must start clean after the junk.
        cur_a = '{$urandom, $urandom, $urandom, $urandom};
        cur_b = '{$urandom, $urandom, $urandom, $urandom};
        gaps  = '{1, 0, 0, 0};
        load();
        stream(16, 1'b0, 1'b0);
        finish_pulse();

        // Reset mid-stream, asserted between clock edges.
        cur_a = '{32'd1, 32'd2, 32'd3, 32'd4};
        cur_b = '{32'd10, 32'd20, 32'd30, 32'd40};
        gaps  = '{0, 0, 0, 0};
        load();
        stream(7, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", vout, 1'b0);
        chk("mid_rst_last", last, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_a", achunk, 32'd0);
        chk("mid_rst_ready", rdy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_ready", rdy, 1'b1);
        cur_a = '{32'd5, 32'd6, 32'd7, 32'd8};
        cur_b = '{32'd1, 32'd1, 32'd1, 32'd1};
        load();
        stream(16, 1'b0, 1'b0);
        finish_pulse();

        // Default-size instance: 64 random chunks, then 4096 beats.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            big_a[i] = $urandom;
            big_b[i] = $urandom;
            bvin     = 1'b1;
            ba       = big_a[i];
            bb       = big_b[i];
        end
        @(negedge clk);
        bvin   = 1'b0;
        brin   = 1'b1;
        k      = 0;
        lasts  = 0;
        dones  = 0;
        maxpad = 0;
        for (int cyc = 0; cyc < 4300; cyc++) begin
            if (bvout) begin
                chk("big_beat", {bachunk, bbchunk, bpad, blast},
                    {big_a[k % 64], big_b[k / 64], 7'(k / 64), 1'((k % 64) == 63)});
                if (blast) lasts++;
                if (int'(bpad) > maxpad) maxpad = int'(bpad);
                k++;
            end
            if (bdone) dones++;
            @(negedge clk);
        end
        chk("big_beats", k, 4096);
        chk("big_lasts", lasts, 64);
        chk("big_dones", dones, 1);
        chk("big_maxpad", maxpad, 63);
        chk("big_idle_ready", brdy, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mul_feed.md
Name: mul_feed

Overview:
- Operand sequencer that drives the chunked multiply/accumulate path from the producer side.
- Captures two NUM_BITS operands, each arriving as REGISTER_SIZE chunks, least-significant chunk first.
- Streams every (a chunk, b chunk) pair row by row, with a per-row start_padding equal to the b chunk index, so the downstream partial-product store aligns each row.
- Sits between the operand source and the multiplier/mul_store pipeline, throttled by the downstream ready.

Parameters:
- REGISTER_SIZE, 32, chunk width in bits.
- NUM_BITS, 2048, operand width in bits; must be a multiple of REGISTER_SIZE. CHUNKS = NUM_BITS/REGISTER_SIZE.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- a_in  input  REGISTER_SIZE  operand A chunk, LSW first.
- b_in  input  REGISTER_SIZE  operand B chunk, LSW first.
- valid_in  input  1  a_in/b_in beat valid; accepted only while ready_out=1.
- ready_out  output  1  high while loading operands.
- a_chunk_out  output  REGISTER_SIZE  A chunk [col].
- b_chunk_out  output  REGISTER_SIZE  B chunk [row].
- start_padding_out  output  $clog2(CHUNKS)+1  current row index.
- valid_out  output  1  output beat valid.
- ready_in  input  1  downstream accepts the beat; transfer = valid_out && ready_in.
- last_out  output  1  high on the final beat of each row (col == CHUNKS-1).
- done_out  output  1  one-cycle pulse after the final beat of the final row.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state LOAD; load_cnt, row, col all 0.
  - valid_out=0, done_out=0, ready_out=1 (while rst_in=0 and after release).
  - a_chunk_out, b_chunk_out, start_padding_out and last_out = 0.
  - Operand storage is not cleared (contents are don't-care).
- States: LOAD -> STREAM -> DONE -> LOAD.
- LOAD:
  - ready_out=1, valid_out=0.
  - Each cycle with valid_in=1 writes a_mem[load_cnt]<=a_in and b_mem[load_cnt]<=b_in, then increments load_cnt.
  - Cycles with valid_in=0 leave everything unchanged (gaps allowed).
  - On the beat where load_cnt==CHUNKS-1: load_cnt<=0, row<=0, col<=0, go to STREAM. ready_out falls and valid_out rises on the next cycle (one-cycle latency).
- STREAM:
  - ready_out=0; valid_in is ignored and storage is not written.
  - valid_out=1 continuously; it never depends combinationally on ready_in.
  - Output values:
    - a_chunk_out=a_mem[col]
    - b_chunk_out=b_mem[row]
    - start_padding_out=row
    - last_out=(col==CHUNKS-1)
  - All outputs are functions of registered state only, with no combinational path from ready_in.
  - On transfer:
    - If col<CHUNKS-1: col++.
    - Otherwise col<=0 and row++.
    - If row==CHUNKS-1 and col==CHUNKS-1: go to DONE instead.
  - With ready_in=0, all outputs hold stable.
  - Total beats per operand pair = CHUNKS*CHUNKS.
- DONE:
  - One cycle only: valid_out=0, done_out=1, ready_out=0.
  - Next state LOAD (ready_out=1 on the following cycle).
- Reset mid-operation: outputs drop immediately (asynchronously). After release, operation starts in LOAD and any in-progress stream is abandoned.
- Widths: counters sized $clog2(CHUNKS)+1. row and col wrap only under the rules above and never exceed CHUNKS-1 while in STREAM.

Test Plan:
- Use NUM_BITS=128, REGISTER_SIZE=32 (CHUNKS=4) unless noted.
- Reset: assert rst_in=0 mid-cycle -> valid_out, done_out, last_out go to 0 without waiting for a clock edge; ready_out=1 after release.
- Basic stream: load A chunks 1,2,3,4 and B chunks 10,20,30,40 over 4 back-to-back beats, ready_in=1 -> ready_out=0 and valid_out=1 on the cycle after the 4th beat. Then 16 consecutive beats: (1,10,0), (2,10,0), (3,10,0), (4,10,0,last), (1,20,1) ... (4,40,3,last). done_out pulses on the next cycle, and ready_out=1 on the cycle after that.
- Backpressure: same load, ready_in alternating 1/0 with random holds -> identical 16-beat sequence. Outputs stay unchanged on every cycle with ready_in=0; no beat is duplicated or skipped.
- Load gaps plus ignored input: valid_in pattern 1,0,0,1,1,0,1 -> exactly 4 chunks captured. valid_in=1 with data 0xDEAD during STREAM -> stream values unaffected, and the next load starts clean.
- Reset mid-stream: assert rst_in=0 after beat 7 -> valid_out=0 at once. After release, load a new pair (A=5,6,7,8; B=1,1,1,1) -> full 16-beat sequence starting at (5,1,0).
- Default parameters (CHUNKS=64): random operands, ready_in=1 -> 4096 beats; start_padding_out reaches 63; exactly 64 last_out pulses and 1 done_out pulse.
